// File: rtl/truth_table_capture.sv
// Exhaustive 3-input sweep with truth-table capture and compare against EXPECTED.
// Optional first-mismatch reporting is enabled by defining TT_FIRST_FAIL_EN.
module truth_table_capture #(
  parameter int         SETTLE   = 2,
  parameter logic [7:0] EXPECTED = 8'hE8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [3:0] err_cnt,
  output logic [1:0] state_dbg,
  output logic       pass
`ifdef TT_FIRST_FAIL_EN
  ,
  output logic [2:0] first_fail,
  output logic       fail_seen
`endif
);

  // Handshake: start is a single-cycle request with no ready. It is acted on
  // only in IDLE or DONE; while busy it is ignored and the sweep runs on.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       sample;
  logic       launch;

  assign sample = (state == SWEEP) && (cnt == SETTLE_M1);
  assign launch = ((state == IDLE) || (state == DONE)) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (sample && (idx == 3'd7)) state_nxt = DONE;
      DONE:    if (start) state_nxt = SWEEP;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state == SWEEP);
    done      = (state == DONE);
    {a, b, c} = busy ? idx : 3'b000;
    pass      = done && (err_cnt == 4'd0);
    state_dbg = state;
  end

  // Sweep datapath: vector index, settle counter and captured results
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 3'd0;
      cnt       <= 4'd0;
      table_out <= 8'h00;
      err_cnt   <= 4'd0;
    end else if (launch) begin
      idx       <= 3'd0;
      cnt       <= 4'd0;
      table_out <= 8'h00;
      err_cnt   <= 4'd0;
    end else if (state == SWEEP) begin
      if (sample) begin
        table_out[idx] <= y;
        if (y != EXPECTED[idx]) err_cnt <= err_cnt + 4'd1;
        cnt <= 4'd0;
        // Leaving for DONE at idx 7 keeps idx from wrapping
        if (idx != 3'd7) idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

`ifdef TT_FIRST_FAIL_EN
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      first_fail <= 3'd0;
      fail_seen  <= 1'b0;
    end else if (sample && (y != EXPECTED[idx]) && !fail_seen) begin
      first_fail <= idx;
      fail_seen  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: reset/idle, good, stuck-at-0,
// inverted DUT, start while busy, and reset mid-sweep.
module tb_truth_table_capture;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       y;
  logic       a, b, c, busy, done, pass;
  logic [7:0] table_out;
  logic [3:0] err_cnt;
  logic [1:0] state_dbg;
`ifdef TT_FIRST_FAIL_EN
  logic [2:0] first_fail;
  logic       fail_seen;
`endif

  int mode = 0;  // 0: majority, 1: stuck-at-0, 2: inverted majority
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  truth_table_capture #(.SETTLE(SETTLE), .EXPECTED(8'hE8)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y),
    .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .table_out(table_out), .err_cnt(err_cnt), .state_dbg(state_dbg),
    .pass(pass)
`ifdef TT_FIRST_FAIL_EN
    , .first_fail(first_fail), .fail_seen(fail_seen)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Model DUT under test
  always_comb begin
    case (mode)
      1:       y = 1'b0;
      2:       y = ~((a & b) | (a & c) | (b & c));
      default: y = (a & b) | (a & c) | (b & c);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {13'd0, a, b, c, busy, done, pass, err_cnt, table_out}, 32'd0);
  endtask

  // Drives one sweep and scores vector sequence, busy length and results
  task automatic run_sweep(input int m, input bit restart,
                           input logic [7:0] exp_tab, input logic [3:0] exp_err);
    int  busy_cycles;
    bit  ended;
    busy_cycles = 0;
    ended = 0;
    mode = m;
    exp_q.delete();
    for (int v = 0; v < 8; v++)
      for (int s = 0; s < SETTLE; s++) exp_q.push_back(v[2:0]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clear_table", {24'd0, table_out}, 32'd0);
    check("clear_done", {31'd0, done}, 32'd0);
    for (int cyc = 0; cyc < 40 && !ended; cyc++) begin
      if (busy) begin
        busy_cycles++;
        if (exp_q.size() > 0) check("vector", {29'd0, a, b, c}, {29'd0, exp_q.pop_front()});
        else check("extra_busy", 32'd1, 32'd0);
        if (restart && busy_cycles == 5) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        ended = 1;
      end
    end
    check("sweep_ended", {31'd0, ended}, 32'd1);
    check("busy_len", busy_cycles, 8 * SETTLE);
    check("done", {31'd0, done}, 32'd1);
    check("abc_done", {29'd0, a, b, c}, 32'd0);
    check("table", {24'd0, table_out}, {24'd0, exp_tab});
    check("err_cnt", {28'd0, err_cnt}, {28'd0, exp_err});
    check("pass", {31'd0, pass}, {31'd0, exp_err == 4'd0});
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_reset_outputs("idle");
      @(negedge clk);
    end

    run_sweep(0, 0, 8'hE8, 4'd0);
`ifdef TT_FIRST_FAIL_EN
    check("fail_seen_good", {31'd0, fail_seen}, 32'd0);
`endif
    run_sweep(1, 0, 8'h00, 4'd4);
`ifdef TT_FIRST_FAIL_EN
    check("first_fail", {29'd0, first_fail}, 32'd3);
    check("fail_seen", {31'd0, fail_seen}, 32'd1);
`endif
    run_sweep(2, 0, 8'h17, 4'd8);
    run_sweep(0, 1, 8'hE8, 4'd0);

    // Reset mid-sweep at idx 4
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
        if (busy && ({a, b, c} == 3'd4)) hit = 1;
        else @(negedge clk);
      end
      check("reach_idx4", {31'd0, hit}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
    run_sweep(0, 0, 8'hE8, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
